rng_output_router: RTL and testbench

Parametrised output stage for the TRNG. It replaces the fixed two-port seed/random output buffer with an N-channel router. Each random source (conditioner seed, CTR-DRBG, Trivium, …) gets its own block FIFO with valid/ready ingress and per-source health gating. A CPU request selects a source by type, and the router streams one full block out as OUT_WIDTH-bit slices on the physical output pins.

---
 rtl/rng_output_router.sv | 185 ++++++++++++++++++
 tb/tb_rng_output_router.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/rng_output_router.sv
// rng_output_router: per-source block FIFOs with health gating, streamed out as OUT_WIDTH slices.
// Optional macro RNG_FALLBACK_EN substitutes the lowest good non-empty source for an unavailable one.
module rng_output_router #(
   parameter int NUM_SRC    = 3,
   parameter int SRC_WIDTH  = 256,
   parameter int OUT_WIDTH  = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int TYPE_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                                          clk,
   input  logic                                          rst_n,
   input  logic [NUM_SRC-1:0]                            src_valid_i,
   input  logic [NUM_SRC-1:0][SRC_WIDTH-1:0]             src_data_i,
   output logic [NUM_SRC-1:0]                            src_ready_o,
   input  logic [NUM_SRC-1:0]                            src_good_i,
   input  logic                                          rand_req,
   input  logic [TYPE_W-1:0]                             rand_req_type,
   output logic [OUT_WIDTH-1:0]                          rand_out,
   output logic                                          rand_valid,
   output logic                                          rand_err,
   output logic                                          rand_fallback,
   output logic                                          busy,
   output logic [NUM_SRC-1:0][$clog2(FIFO_DEPTH+1)-1:0]  fifo_level_o
);

   localparam int SLICES = SRC_WIDTH / OUT_WIDTH;
   localparam int CNT_W  = (SLICES > 1) ? $clog2(SLICES) : 1;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = $clog2(FIFO_DEPTH+1);

   typedef enum logic [1:0] {IDLE, LOAD, STREAM, ERR} state_t;

   state_t                            state, state_nx;
   logic                              run_q;
   logic [SRC_WIDTH-1:0]              shreg;
   logic [CNT_W-1:0]                  cnt;
   logic [TYPE_W-1:0]                 srv_idx;
   logic [NUM_SRC-1:0]                push, pop, avail;
   logic [NUM_SRC-1:0][SRC_WIDTH-1:0] head;
   logic [SRC_WIDTH-1:0]              head_sel;
   logic [TYPE_W-1:0]                 sel_idx;
   logic                              sel_ok, srv_good, abort, accept;
   logic                              out_valid_d, err_d, fb_d;
   logic [OUT_WIDTH-1:0]              out_d;
`ifdef RNG_FALLBACK_EN
   logic                              sel_fb, srv_fb, range_ok, fb_found;
`endif

   for (genvar k = 0; k < NUM_SRC; k++) begin : g_fifo
      logic [SRC_WIDTH-1:0] mem [FIFO_DEPTH];
      logic [PTR_W-1:0]     wr_ptr, rd_ptr;
      logic [LVL_W-1:0]     lvl;

      assign fifo_level_o[k] = lvl;
      assign src_ready_o[k]  = run_q & src_good_i[k] & (lvl < LVL_W'(FIFO_DEPTH));
      assign push[k]         = src_valid_i[k] & src_ready_o[k];
      assign head[k]         = mem[rd_ptr];

      always_ff @(posedge clk) begin
         if (push[k]) mem[wr_ptr] <= src_data_i[k];
      end

      // An unhealthy source loses its whole backlog; pop never coincides since it requires good.
      always_ff @(posedge clk) begin
         if (!rst_n || !src_good_i[k]) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lvl    <= '0;
         end else begin
            if (push[k]) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop[k])  rd_ptr <= rd_ptr + PTR_W'(1);
            lvl <= lvl + LVL_W'(push[k]) - LVL_W'(pop[k]);
         end
      end
   end

   always_comb begin
      avail    = '0;
      sel_ok   = 1'b0;
      sel_idx  = '0;
      srv_good = 1'b0;
      head_sel = '0;
`ifdef RNG_FALLBACK_EN
      sel_fb   = 1'b0;
      fb_found = 1'b0;
      range_ok = (int'(rand_req_type) < NUM_SRC);
`endif
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         avail[k] = src_good_i[k] & (fifo_level_o[k] != '0);
         if (rand_req_type == TYPE_W'(k) && avail[k]) begin
            sel_ok  = 1'b1;
            sel_idx = TYPE_W'(k);
         end
         if (srv_idx == TYPE_W'(k)) srv_good = src_good_i[k];
      end
`ifdef RNG_FALLBACK_EN
      if (range_ok && !sel_ok) begin
         for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (!fb_found && avail[k]) begin
               fb_found = 1'b1;
               sel_idx  = TYPE_W'(k);
            end
         end
         sel_ok = fb_found;
         sel_fb = fb_found;
      end
`endif
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         if (sel_idx == TYPE_W'(k)) head_sel = head[k];
      end
   end

   assign abort = ((state == LOAD) || (state == STREAM)) && !srv_good;
   assign busy  = (state != IDLE);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:   if (rand_req) state_nx = sel_ok ? LOAD : ERR;
         LOAD:   state_nx = abort ? IDLE : STREAM;
         STREAM: if (abort || cnt == CNT_W'(SLICES-1)) state_nx = IDLE;
         ERR:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      accept      = (state == IDLE) && rand_req && sel_ok;
      pop         = '0;
      for (int unsigned k = 0; k < NUM_SRC; k++) begin
         pop[k] = accept && (sel_idx == TYPE_W'(k));
      end
      out_valid_d = (state == STREAM) && !abort;
      out_d       = out_valid_d ? shreg[OUT_WIDTH-1:0] : '0;
      err_d       = (state == ERR) || abort;
`ifdef RNG_FALLBACK_EN
      fb_d        = out_valid_d & srv_fb;
`else
      fb_d        = 1'b0;
`endif
   end

   // Outputs are registered, so each slice appears one cycle after its STREAM state cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         run_q         <= 1'b0;
         shreg         <= '0;
         cnt           <= '0;
         srv_idx       <= '0;
         rand_out      <= '0;
         rand_valid    <= 1'b0;
         rand_err      <= 1'b0;
         rand_fallback <= 1'b0;
      end else begin
         run_q         <= 1'b1;
         rand_out      <= out_d;
         rand_valid    <= out_valid_d;
         rand_err      <= err_d;
         rand_fallback <= fb_d;
         if (accept) begin
            shreg   <= head_sel;
            cnt     <= '0;
            srv_idx <= sel_idx;
         end else if (abort) begin
            shreg <= '0;
         end else if (state == STREAM) begin
            shreg <= shreg >> OUT_WIDTH;
            cnt   <= cnt + CNT_W'(1);
         end
      end
   end

`ifdef RNG_FALLBACK_EN
   always_ff @(posedge clk) begin
      if (!rst_n)      srv_fb <= 1'b0;
      else if (accept) srv_fb <= sel_fb;
   end
`endif

endmodule

// File: tb/tb_rng_output_router.sv
// Directed bench for rng_output_router (32-bit blocks, 8-bit slices, depth 4).
module tb_rng_output_router;
   localparam int NS = 3, SW = 32, OW = 8, DEPTH = 4, TW = 2, LW = 3;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic [NS-1:0]         src_valid = '0;
   logic [NS-1:0][SW-1:0] src_data = '0;
   logic [NS-1:0]         src_ready_o;
   logic [NS-1:0]         src_good = '1;
   logic                  rand_req = 1'b0;
   logic [TW-1:0]         rand_req_type = '0;
   logic [OW-1:0]         rand_out;
   logic                  rand_valid, rand_err, rand_fallback, busy;
   logic [NS-1:0][LW-1:0] fifo_level;

   int n_tests = 0;
   int n_fail  = 0;

   rng_output_router #(.NUM_SRC(NS), .SRC_WIDTH(SW), .OUT_WIDTH(OW), .FIFO_DEPTH(DEPTH), .TYPE_W(TW)) dut (
      .clk(clk), .rst_n(rst_n),
      .src_valid_i(src_valid), .src_data_i(src_data), .src_ready_o(src_ready_o), .src_good_i(src_good),
      .rand_req(rand_req), .rand_req_type(rand_req_type),
      .rand_out(rand_out), .rand_valid(rand_valid), .rand_err(rand_err),
      .rand_fallback(rand_fallback), .busy(busy), .fifo_level_o(fifo_level)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         push_en;
      int         push_src;
      logic [31:0] push_data;
      logic [1:0] req_type;
      bit         exp_err;
      bit         exp_fb;
      logic [31:0] exp_data;
      int         lvl_src;
      int         lvl_before;
      int         lvl_after;
   } row_t;

   row_t        rows [7];
   logic [31:0] bdat [5];

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_blk(input int s, input logic [31:0] d);
      bit done = 1'b0;
      src_valid[s] = 1'b1;
      src_data[s]  = d;
      for (int i = 0; i < 20 && !done; i++) begin
         if (src_ready_o[s]) done = 1'b1;
         tick;
      end
      src_valid[s] = 1'b0;
      chk("push_accept", 64'(done), 64'd1);
   endtask

   task automatic check_slices(input logic [31:0] d, input bit exp_fb);
      logic [31:0] w = d;
      for (int i = 0; i < SW / OW; i++) begin
         chk("slice_valid", rand_valid, 1);
         chk("slice_data", rand_out, w[7:0]);
         chk("slice_fb", rand_fallback, exp_fb);
         w = w >> 8;
         tick;
      end
      chk("valid_end", rand_valid, 0);
      chk("out_zero_end", rand_out, 0);
      chk("busy_end", busy, 0);
   endtask

   task automatic serve(input logic [1:0] typ, input bit exp_err, input bit exp_fb, input logic [31:0] exp_data);
      rand_req = 1'b1;
      rand_req_type = typ;
      tick;
      rand_req = 1'b0;
      chk("busy_after_req", busy, 1);
      tick;
      chk("err_t1", rand_err, exp_err);
      chk("valid_t1", rand_valid, 0);
      chk("fb_t1", rand_fallback, 0);
      if (exp_err) begin
         chk("busy_after_err", busy, 0);
         tick;
         chk("err_one_cycle", rand_err, 0);
         chk("valid_after_err", rand_valid, 0);
      end else begin
         tick;
         chk("busy_stream", busy, 1);
         check_slices(exp_data, exp_fb);
      end
   endtask

   initial begin
      rows[0] = '{1'b1, 1, 32'hDDCCBBAA, 2'd1, 1'b0, 1'b0, 32'hDDCCBBAA, 1, 1, 0};
      rows[1] = '{1'b1, 2, 32'hCAFEF00D, 2'd2, 1'b0, 1'b0, 32'hCAFEF00D, 2, 1, 0};
      rows[2] = '{1'b0, 0, 32'h0,        2'd2, 1'b1, 1'b0, 32'h0,        2, 0, 0};
      rows[3] = '{1'b1, 0, 32'h55667788, 2'd3, 1'b1, 1'b0, 32'h0,        0, 1, 1};
      rows[4] = '{1'b0, 0, 32'h0,        2'd0, 1'b0, 1'b0, 32'h55667788, 0, 1, 0};
`ifdef RNG_FALLBACK_EN
      rows[5] = '{1'b1, 0, 32'h11223344, 2'd1, 1'b0, 1'b1, 32'h11223344, 0, 1, 0};
      rows[6] = '{1'b0, 0, 32'h0,        2'd0, 1'b1, 1'b0, 32'h0,        0, 0, 0};
`else
      rows[5] = '{1'b1, 0, 32'h11223344, 2'd1, 1'b1, 1'b0, 32'h0,        0, 1, 1};
      rows[6] = '{1'b0, 0, 32'h0,        2'd0, 1'b0, 1'b0, 32'h11223344, 0, 1, 0};
`endif
      bdat = '{32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D, 32'h14131211};

      tick;
      tick;
      chk("rst_out", rand_out, 0);
      chk("rst_valid", rand_valid, 0);
      chk("rst_err", rand_err, 0);
      chk("rst_fb", rand_fallback, 0);
      chk("rst_busy", busy, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_ready", src_ready_o, 0);
      rst_n = 1'b1;
      tick;
      chk("ready_after_rst", src_ready_o, 3'b111);

      for (int i = 0; i < 7; i++) begin
         if (rows[i].push_en) push_blk(rows[i].push_src, rows[i].push_data);
         chk("lvl_before", fifo_level[rows[i].lvl_src], rows[i].lvl_before);
         serve(rows[i].req_type, rows[i].exp_err, rows[i].exp_fb, rows[i].exp_data);
         chk("lvl_after", fifo_level[rows[i].lvl_src], rows[i].lvl_after);
      end

      // Fill src0 past its depth; the fifth block must wait for a pop.
      src_valid[0] = 1'b1;
      for (int i = 0; i < 4; i++) begin
         src_data[0] = bdat[i];
         chk("fill_ready", src_ready_o[0], 1);
         tick;
      end
      src_data[0] = bdat[4];
      chk("full_level", fifo_level[0], 4);
      chk("full_ready", src_ready_o[0], 0);
      tick;
      chk("full_hold", fifo_level[0], 4);
      rand_req = 1'b1;
      rand_req_type = 2'd0;
      tick;
      rand_req = 1'b0;
      chk("pop_no_push", fifo_level[0], 3);
      chk("ready_back", src_ready_o[0], 1);
      tick;
      chk("fifth_in", fifo_level[0], 4);
      src_valid[0] = 1'b0;
      tick;
      check_slices(bdat[0], 1'b0);
      serve(2'd0, 1'b0, 1'b0, bdat[1]);
      src_good[0] = 1'b0;
      tick;
      chk("flush_level", fifo_level[0], 0);
      chk("flush_ready", src_ready_o[0], 0);
      src_good[0] = 1'b1;
      tick;
      chk("good_ready", src_ready_o[0], 1);

      // Health drop on the served source after the second slice.
      push_blk(2, 32'h44332211);
      rand_req = 1'b1;
      rand_req_type = 2'd2;
      tick;
      rand_req = 1'b0;
      tick;
      tick;
      chk("ab_slice0", rand_out, 8'h11);
      tick;
      chk("ab_slice1", rand_out, 8'h22);
      src_good[2] = 1'b0;
      tick;
      chk("ab_valid", rand_valid, 0);
      chk("ab_out", rand_out, 0);
      chk("ab_err", rand_err, 1);
      chk("ab_level", fifo_level[2], 0);
      chk("ab_ready", src_ready_o[2], 0);
      tick;
      chk("ab_err_pulse", rand_err, 0);
      chk("ab_busy", busy, 0);
      chk("ab_ready_hold", src_ready_o[2], 0);
      src_good[2] = 1'b1;
      tick;
      chk("ab_ready_back", src_ready_o[2], 1);

      // Reset asserted for one edge in the middle of a stream.
      push_blk(1, 32'hA1B2C3D4);
      push_blk(1, 32'hE5F60718);
      rand_req = 1'b1;
      rand_req_type = 2'd1;
      tick;
      rand_req = 1'b0;
      tick;
      tick;
      chk("mr_stream", rand_valid, 1);
      rst_n = 1'b0;
      tick;
      chk("mr_valid", rand_valid, 0);
      chk("mr_out", rand_out, 0);
      chk("mr_level", fifo_level, 0);
      chk("mr_busy", busy, 0);
      chk("mr_ready", src_ready_o, 0);
      rst_n = 1'b1;
      tick;
      chk("mr_ready_back", src_ready_o, 3'b111);
      push_blk(1, 32'h9988AA77);
      serve(2'd1, 1'b0, 1'b0, 32'h9988AA77);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
